struct_array_fill: RTL and testbench



---
 rtl/struct_array_fill.sv | 101 ++++++++++
 tb/tb_struct_array_fill.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/struct_array_fill.sv
// struct_array_fill: sequential filler for an N-entry packed struct array.
// Starting from IDLE, an accepted start latches the pattern mode and seed and
// clears every valid bit. The block then writes one entry per clock with an
// index-derived pattern. A pulse on done marks the end of the pass. clear
// zeroes the whole array and aborts any pass in progress.
module struct_array_fill #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       seed,
  output logic [N*(W+1)-1:0] a_out,
  output logic               busy,
  output logic               done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {IDLE, FILL} state_t;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
  } entry_t;

  entry_t [N-1:0] arr;
  state_t         state;
  logic [IW-1:0]  idx;
  logic [1:0]     mode_q;
  logic [W-1:0]   seed_q;

  assign a_out = arr;

  // Index-derived payload. The index is resized to W before any arithmetic,
  // so mode 3 inverts at payload width and does not invert at index width.
  function automatic logic [W-1:0] pattern(input logic [1:0]    md,
                                           input logic [W-1:0]  sd,
                                           input logic [IW-1:0] i);
    logic [W-1:0] iw;
    iw = W'(i);
    case (md)
      2'd0:    pattern = W'(i[0]);
      2'd1:    pattern = iw;
      2'd2:    pattern = sd + iw;
      default: pattern = ~iw;
    endcase
  endfunction

  // Control FSM and array storage. clear takes priority over everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr    <= '0;
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= '0;
      seed_q <= '0;
    end else if (clear) begin
      arr   <= '0;
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q <= mode;
            seed_q <= seed;
            idx    <= '0;
            for (int unsigned j = 0; j < N; j++) begin
              arr[j].valid <= 1'b0;
            end
            state <= FILL;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          arr[idx] <= '{valid: 1'b1, data: pattern(mode_q, seed_q, idx)};
          if (idx == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_struct_array_fill.sv
// Bench for struct_array_fill. Four instances run side by side: (N,W) =
// (4,1), (8,3), (4,4) and (1,1). All four share one set of stimulus inputs.
// A pass-level model predicts every instance's outputs on every cycle.
// Hand-computed literals pin the model at key points.
module tb_struct_array_fill;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] seed = 4'd0;

  logic [7:0]  a0;
  logic [31:0] a1;
  logic [19:0] a2;
  logic [1:0]  a3;
  logic [3:0]  bsy;
  logic [3:0]  dn;
  logic [31:0] aout [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  struct_array_fill #(.N(4), .W(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .seed(seed[0:0]), .a_out(a0), .busy(bsy[0]), .done(dn[0]));
  struct_array_fill #(.N(8), .W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .seed(seed[2:0]), .a_out(a1), .busy(bsy[1]), .done(dn[1]));
  struct_array_fill #(.N(4), .W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .seed(seed[3:0]), .a_out(a2), .busy(bsy[2]), .done(dn[2]));
  struct_array_fill #(.N(1), .W(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .seed(seed[0:0]), .a_out(a3), .busy(bsy[3]), .done(dn[3]));

  always_comb begin
    aout[0] = 32'(a0);
    aout[1] = a1;
    aout[2] = 32'(a2);
    aout[3] = 32'(a3);
  end

  function automatic int nn(input int i);
    case (i)
      0: return 4;
      1: return 8;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int ww(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int pat(input int md, input int sd, input int k, input int w);
    int m;
    m = (1 << w) - 1;
    case (md)
      0: return k & 1;
      1: return k & m;
      2: return (sd + k) & m;
      default: return (~k) & m;
    endcase
  endfunction

  // Pass-level model: position in pass, latched settings, entry contents.
  int mk    [4];
  int mmode [4];
  int mseed [4];
  bit mbusy [4];
  bit mdone [4];
  bit mval  [4][8];
  int mdat  [4][8];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || clear) begin
        mk[i] = 0; mbusy[i] = 0; mdone[i] = 0;
        if (!rst_n) begin
          mmode[i] = 0; mseed[i] = 0;
        end
        for (int j = 0; j < 8; j++) begin
          mval[i][j] = 0; mdat[i][j] = 0;
        end
      end else if (mbusy[i]) begin
        mval[i][mk[i]] = 1;
        mdat[i][mk[i]] = pat(mmode[i], mseed[i], mk[i], ww(i));
        if (mk[i] == nn(i) - 1) begin
          mbusy[i] = 0; mdone[i] = 1; mk[i] = 0;
        end else begin
          mk[i] = mk[i] + 1; mdone[i] = 0;
        end
      end else begin
        mdone[i] = 0;
        if (start) begin
          mbusy[i] = 1; mk[i] = 0;
          mmode[i] = int'(mode);
          mseed[i] = int'(seed) & ((1 << ww(i)) - 1);
          for (int j = 0; j < 8; j++) mval[i][j] = 0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_a(input int i);
    logic [31:0] r;
    int e;
    r = '0;
    for (int j = 0; j < nn(i); j++) begin
      e = (mval[i][j] ? (1 << ww(i)) : 0) | mdat[i][j];
      r = r | (32'(e) << (j * (ww(i) + 1)));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model_a_out%0d", i), aout[i], exp_a(i));
        chk($sformatf("model_busy%0d", i), 32'(bsy[i]), 32'(mbusy[i]));
        chk($sformatf("model_done%0d", i), 32'(dn[i]), 32'(mdone[i]));
      end
    end
  end

  task automatic go(input logic [1:0] m, input logic [3:0] s);
    mode = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_a0", 32'(a0), 32'h0);
    chk("reset_busy", 32'(bsy), 32'h0);

    // Mode 0 pass.
    go(2'd0, 4'd0);
    repeat (4) @(negedge clk);
    chk("m0_a0", 32'(a0), 32'hEE);
    chk("m0_done0", 32'(dn[0]), 32'h1);
    chk("m0_busy0", 32'(bsy[0]), 32'h0);
    @(negedge clk);
    chk("m0_done0_low", 32'(dn[0]), 32'h0);
    repeat (6) @(negedge clk);

    // Mode 2 with wrap. Valid bits clear on accept, and data is retained.
    go(2'd2, 4'd6);
    chk("m2_validclr_a1", a1, 32'h10101010);
    chk("m2_busy1", 32'(bsy[1]), 32'h1);
    repeat (8) @(negedge clk);
    chk("m2_a1", a1, 32'hDCBA98FE);
    chk("m2_done1", 32'(dn[1]), 32'h1);
    repeat (2) @(negedge clk);

    // Mode 3. mode, seed and start are disturbed mid-pass.
    mode = 2'd3; seed = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 2'd1; seed = 4'd9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("m3_a2", 32'(a2), 32'hE77DF);
    chk("m3_done2", 32'(dn[2]), 32'h1);
    repeat (10) @(negedge clk);

    // Clear after entry 1 is written, then a fresh pass.
    go(2'd1, 4'd0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_a2", 32'(a2), 32'h0);
    chk("clr_a1", a1, 32'h0);
    chk("clr_busy2", 32'(bsy[2]), 32'h0);
    @(negedge clk);
    chk("clr_nodone2", 32'(dn[2]), 32'h0);
    go(2'd1, 4'd0);
    repeat (4) @(negedge clk);
    chk("fresh_a2", 32'(a2), 32'h9CA30);
    chk("fresh_done2", 32'(dn[2]), 32'h1);
    repeat (6) @(negedge clk);

    // Clear on the final write edge of the N=1 instance suppresses done.
    go(2'd0, 4'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrlast_done3", 32'(dn[3]), 32'h0);
    chk("clrlast_a3", 32'(a3), 32'h0);

    // clear and start together in IDLE.
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clrstart_busy", 32'(bsy), 32'h0);
    chk("clrstart_a2", 32'(a2), 32'h0);
    @(negedge clk);
    chk("clrstart_busy_after", 32'(bsy), 32'h0);

    // Back-to-back passes with start held high.
    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("b2b_done0_a", 32'(dn[0]), 32'h1);
    @(negedge clk);
    chk("b2b_done0_gap", 32'(dn[0]), 32'h0);
    chk("b2b_busy0", 32'(bsy[0]), 32'h1);
    repeat (4) @(negedge clk);
    chk("b2b_done0_b", 32'(dn[0]), 32'h1);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset mid-pass. Outputs must drop before the next clock edge.
    go(2'd1, 4'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a0", 32'(a0), 32'h0);
    chk("arst_a1", a1, 32'h0);
    chk("arst_a2", 32'(a2), 32'h0);
    chk("arst_busy", 32'(bsy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // N=1 instance with a single fill cycle.
    go(2'd0, 4'd0);
    chk("n1_busy3", 32'(bsy[3]), 32'h1);
    chk("n1_a3_pre", 32'(a3), 32'h0);
    @(negedge clk);
    chk("n1_a3", 32'(a3), 32'h2);
    chk("n1_done3", 32'(dn[3]), 32'h1);
    @(negedge clk);
    chk("n1_done3_low", 32'(dn[3]), 32'h0);
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
